// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-lite bus bundle between a master (driver) and the SRAM slave.
interface ahb_lite_sram_slave_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int RW = 2
);
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic          error;
    logic [DW-1:0] hrdata;
    logic          hreadyout;
    logic [RW-1:0] hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready, error,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready, error,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite SRAM slave: byte-lane writes, wait states, read-after-write forwarding, 2-cycle ERROR.
// Define AHB_ALIGN_CHECK_EN to make addresses misaligned to hsize an error source.
module ahb_lite_sram_slave #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int RW          = 2,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    ahb_lite_sram_slave_if.slave  bus
);
    localparam int NB = DW / 8;
    localparam int BL = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = 4;
    localparam logic [RW-1:0] OKAY  = RW'(0);
    localparam logic [RW-1:0] ERROR = RW'(1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t          state;
    logic [CW-1:0]   wcnt;
    logic            ready_q;
    logic [RW-1:0]   resp_q;
    logic [DW-1:0]   rdata_q;

    logic            write_p0;
    logic [IW-1:0]   idx_p0;
    logic [NB-1:0]   be_p0;

    logic            wr_vld_p1;
    logic [IW-1:0]   wr_idx_p1;
    logic [NB-1:0]   wr_be_p1;
    logic [DW-1:0]   wr_data_p1;

    logic [DW-1:0]   mem [DEPTH];

    logic            accept;
    logic            acc_err;
    logic [IW-1:0]   acc_idx;
    logic [NB-1:0]   acc_be;
    logic [DW-1:0]   rd_word;
    logic            wr_done;
    logic            unused_sideband;

    function automatic logic [NB-1:0] lane_mask(input logic [2:0] sz, input logic [BL-1:0] lo);
        lane_mask = '0;
        for (int i = 0; i < NB; i++)
            if ((i >> sz) == (int'(lo) >> sz)) lane_mask[i] = 1'b1;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] base, input logic [NB-1:0] be,
                                            input logic [DW-1:0] wd);
        merge = base;
        for (int i = 0; i < NB; i++)
            if (be[i]) merge[8*i +: 8] = wd[8*i +: 8];
    endfunction

`ifdef AHB_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [2:0] sz, input logic [BL-1:0] lo);
        return ((int'(lo) >> sz) << sz) != int'(lo);
    endfunction
`endif

    assign bus.hreadyout   = ready_q;
    assign bus.hresp       = resp_q;
    assign bus.hrdata      = rdata_q;
    assign unused_sideband = ^{bus.hburst, bus.hprot};

    // ready_q is high exactly in IDLE, DATA and ERR2, the only states that may take a new address
    assign accept  = bus.hsel & bus.hready & bus.htrans[1] & ready_q;
    assign acc_idx = bus.haddr[BL +: IW];
    assign acc_be  = lane_mask(bus.hsize, bus.haddr[BL-1:0]);
    assign wr_done = (state == S_DATA) && write_p0;

    always_comb begin
        acc_err = bus.error || ((bus.haddr >> BL) >= AW'(DEPTH)) || (bus.hsize > 3'(BL));
`ifdef AHB_ALIGN_CHECK_EN
        acc_err = acc_err || misaligned(bus.hsize, bus.haddr[BL-1:0]);
`else
        acc_err = acc_err;
`endif
    end

    // Forward both the write committing this edge and the one completing this cycle
    always_comb begin
        rd_word = mem[acc_idx];
        if (wr_vld_p1 && wr_idx_p1 == acc_idx) rd_word = merge(rd_word, wr_be_p1, wr_data_p1);
        if (wr_done && idx_p0 == acc_idx)      rd_word = merge(rd_word, be_p0, bus.hwdata);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            ready_q   <= 1'b1;
            resp_q    <= OKAY;
            rdata_q   <= '0;
            write_p0  <= 1'b0;
            wr_vld_p1 <= 1'b0;
        end else begin
            wr_vld_p1 <= wr_done;
            if (accept) begin
                write_p0 <= bus.hwrite;
                if (acc_err) begin
                    state   <= S_ERR1;
                    ready_q <= 1'b0;
                    resp_q  <= ERROR;
                    if (!bus.hwrite) rdata_q <= '0;
                end else begin
                    resp_q <= OKAY;
                    if (!bus.hwrite) rdata_q <= rd_word;
                    if (WAIT_STATES > 0) begin
                        state   <= S_WAIT;
                        ready_q <= 1'b0;
                        wcnt    <= CW'(WAIT_STATES - 1);
                    end else begin
                        state   <= S_DATA;
                        ready_q <= 1'b1;
                    end
                end
            end else begin
                case (state)
                    S_WAIT: begin
                        if (wcnt == '0) begin
                            state   <= S_DATA;
                            ready_q <= 1'b1;
                        end else begin
                            wcnt <= wcnt - 1'b1;
                        end
                    end
                    S_ERR1: begin
                        state   <= S_ERR2;
                        ready_q <= 1'b1;
                    end
                    default: begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= OKAY;
                    end
                endcase
            end
        end
    end

    // Stage p0: address phase latched; stage p1: completed write waiting to commit
    always_ff @(posedge hclk) begin
        if (accept) begin
            idx_p0 <= acc_idx;
            be_p0  <= acc_be;
        end
        if (wr_done) begin
            wr_idx_p1  <= idx_p0;
            wr_be_p1   <= be_p0;
            wr_data_p1 <= bus.hwdata;
        end
    end

    always_ff @(posedge hclk) begin
        if (wr_vld_p1) begin
            for (int i = 0; i < NB; i++)
                if (wr_be_p1[i]) mem[wr_idx_p1][8*i +: 8] <= wr_data_p1[8*i +: 8];
        end
    end
endmodule
